gain_stage: RTL and testbench

GAIN_STAGE -- requirements
Module: gain_stage

---
 rtl/gain_stage.sv | 131 +++++++++++++
 tb/tb_gain_stage.sv | 217 +++++++++++++++++++++
 2 files changed

// File: rtl/gain_stage.sv
// Ramped-gain fixed-point multiplier: per-sample gain slewing toward a target, 2-cycle pipeline.
// Define GAIN_STAGE_SATURATE_EN to clamp the scaled sample instead of wrapping it.
module gain_stage #(
    parameter int fractional_size = 12,
    parameter int operand_size    = 32,
    parameter int ramp_step       = 64
) (
    input  logic                           clk,
    input  logic                           rst_n,
    input  logic                           in_valid,
    input  logic signed [operand_size-1:0] in_sample,
    input  logic                           gain_load,
    input  logic signed [operand_size-1:0] target_gain,
    output logic                           out_valid,
    output logic signed [operand_size-1:0] out_sample,
    output logic                           sat_flag,
    output logic                           gain_settled
);

    localparam int PW = 2 * operand_size;
    localparam int DW = operand_size + 1;
    localparam logic signed [operand_size-1:0] UNITY =
        {{(operand_size-1){1'b0}}, 1'b1} << fractional_size;
    localparam logic signed [DW-1:0] STEP = DW'(ramp_step);

    typedef enum logic [1:0] {HOLD, RAMP_UP, RAMP_DOWN} state_t;

    state_t                         state, state_next;
    logic signed [operand_size-1:0] gain, gain_next;
    logic signed [operand_size-1:0] target, target_next;
    logic signed [DW-1:0]           diff, diff_next;

    logic signed [operand_size-1:0] sample_p1;
    logic signed [operand_size-1:0] gain_p1;
    logic                           vld_p1;

    logic signed [PW-1:0]           prod;
    logic signed [PW-1:0]           reduced;
    logic signed [operand_size-1:0] res;
    logic                           sat;

    logic signed [operand_size-1:0] sample_p2;
    logic                           sat_p2;
    logic                           vld_p2;

`ifdef GAIN_STAGE_SATURATE_EN
    // Returns {clipped, value}; the value fits when all bits above the result MSB are sign copies.
    function automatic logic [operand_size:0] saturate(input logic signed [PW-1:0] v);
        logic [PW-operand_size:0] hi;
        hi = v[PW-1:operand_size-1];
        if (&hi || ~|hi)
            return {1'b0, v[operand_size-1:0]};
        else if (v[PW-1])
            return {1'b1, 1'b1, {(operand_size-1){1'b0}}};
        else
            return {1'b1, 1'b0, {(operand_size-1){1'b1}}};
    endfunction
`endif

    // Gain control: difference is one bit wider so extreme gains cannot overflow.
    always_comb begin
        target_next = gain_load ? target_gain : target;
        gain_next   = gain;
        diff        = DW'(target) - DW'(gain);
        if (in_valid && (state != HOLD)) begin
            if ((diff <= STEP) && (diff >= -STEP))
                gain_next = target;
            else if (diff > 0)
                gain_next = operand_size'(DW'(gain) + STEP);
            else
                gain_next = operand_size'(DW'(gain) - STEP);
        end
        diff_next = DW'(target_next) - DW'(gain_next);
        if (diff_next == '0)
            state_next = HOLD;
        else if (diff_next > 0)
            state_next = RAMP_UP;
        else
            state_next = RAMP_DOWN;
    end

    assign gain_settled = (state == HOLD) || !rst_n;

    // Stage 1: capture the sample together with the gain in force before this cycle's update.
    always_ff @(posedge clk) begin
        if (in_valid) begin
            sample_p1 <= in_sample;
            gain_p1   <= gain;
        end
    end

    // Stage 2: full-width product reduced by the fractional bits.
    assign prod    = PW'(sample_p1) * PW'(gain_p1);
    assign reduced = prod >>> fractional_size;

`ifdef GAIN_STAGE_SATURATE_EN
    assign {sat, res} = saturate(reduced);
`else
    logic unused_hi;
    assign unused_hi = ^reduced[PW-1:operand_size];
    assign res       = reduced[operand_size-1:0];
    assign sat       = 1'b0;
`endif

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state     <= HOLD;
            gain      <= UNITY;
            target    <= UNITY;
            vld_p1    <= 1'b0;
            vld_p2    <= 1'b0;
            sample_p2 <= '0;
            sat_p2    <= 1'b0;
        end else begin
            state  <= state_next;
            gain   <= gain_next;
            target <= target_next;
            vld_p1 <= in_valid;
            vld_p2 <= vld_p1;
            if (vld_p1) begin
                sample_p2 <= res;
                sat_p2    <= sat;
            end
        end
    end

    assign out_valid  = vld_p2;
    assign out_sample = sample_p2;
    assign sat_flag   = sat_p2;

endmodule

// File: tb/tb_gain_stage.sv
// Directed bench for gain_stage: vector table for ramp/saturation, hand sequences for latency and reset.
module tb_gain_stage;

    logic               clk;
    logic               rst_n;
    logic               in_valid;
    logic signed [31:0] in_sample;
    logic               gain_load;
    logic signed [31:0] target_gain;
    logic               out_valid;
    logic signed [31:0] out_sample;
    logic               sat_flag;
    logic               gain_settled;

    gain_stage #(
        .fractional_size(12),
        .operand_size(32),
        .ramp_step(1024)
    ) dut (
        .clk(clk),
        .rst_n(rst_n),
        .in_valid(in_valid),
        .in_sample(in_sample),
        .gain_load(gain_load),
        .target_gain(target_gain),
        .out_valid(out_valid),
        .out_sample(out_sample),
        .sat_flag(sat_flag),
        .gain_settled(gain_settled)
    );

    typedef struct {
        logic ld;
        int   tgt;
        logic iv;
        int   smp;
        int   exp_out;
        logic exp_sat;
        logic exp_settled;
    } vec_t;

    vec_t   vecs[$];
    int     exp_out_q[$];
    logic   exp_sat_q[$];
    int     checks   = 0;
    int     failures = 0;
    int     exp_big_pos;
    int     exp_big_neg;
    logic   exp_big_sat;

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #200000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "watchdog expired");
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string name, input longint act, input longint exp);
        checks++;
        if (act != exp) begin
            failures++;
            $display("FAIL %s actual=%0d required=%0d", name, act, exp);
        end
    endtask

    function automatic void add(input logic ld, input int tgt, input logic iv, input int smp,
                                input int eo, input logic es, input logic st);
        vec_t v;
        v.ld = ld; v.tgt = tgt; v.iv = iv; v.smp = smp;
        v.exp_out = eo; v.exp_sat = es; v.exp_settled = st;
        vecs.push_back(v);
    endfunction

    // Scoreboard: every out_valid must match the oldest outstanding expectation.
    always @(negedge clk) begin
        if (out_valid) begin
            if (exp_out_q.size() == 0) begin
                checks++;
                failures++;
                $display("FAIL unexpected_out_valid actual=%0d required=none", out_sample);
            end else begin
                int   eo;
                logic es;
                eo = exp_out_q.pop_front();
                es = exp_sat_q.pop_front();
                check("out_sample", longint'(out_sample), longint'(eo));
                check("sat_flag", longint'(sat_flag), longint'(es));
            end
        end
    end

    initial begin
`ifdef GAIN_STAGE_SATURATE_EN
        exp_big_pos = 32'sh7fff_ffff;
        exp_big_neg = 32'sh8000_0000;
        exp_big_sat = 1'b1;
`else
        exp_big_pos = 0;
        exp_big_neg = 0;
        exp_big_sat = 1'b0;
`endif
        // ramp up to 8192 in 1024 steps
        add(1, 8192, 0, 0,    0,    0, 0);
        add(0, 0,    1, 4096, 4096, 0, 0);
        add(0, 0,    1, 4096, 5120, 0, 0);
        add(0, 0,    1, 4096, 6144, 0, 0);
        add(0, 0,    1, 4096, 7168, 0, 1);
        add(0, 0,    1, 4096, 8192, 0, 1);
        // back down to unity, then up again with an idle gap
        add(1, 4096, 0, 0,    0,    0, 0);
        add(0, 0,    1, 4096, 8192, 0, 0);
        add(0, 0,    1, 4096, 7168, 0, 0);
        add(0, 0,    1, 4096, 6144, 0, 0);
        add(0, 0,    1, 4096, 5120, 0, 1);
        add(1, 8192, 0, 0,    0,    0, 0);
        add(0, 0,    1, 4096, 4096, 0, 0);
        for (int i = 0; i < 10; i++) add(0, 0, 0, 0, 0, 0, 0);
        add(0, 0,    1, 4096, 5120, 0, 0);
        add(0, 0,    1, 4096, 6144, 0, 0);
        add(0, 0,    1, 4096, 7168, 0, 1);
        // reverse direction mid-ramp
        add(1, 0,    0, 0,    0,    0, 0);
        add(0, 0,    1, 4096, 8192, 0, 0);
        add(0, 0,    1, 4096, 7168, 0, 0);
        add(1, 8192, 0, 0,    0,    0, 0);
        add(0, 0,    1, 4096, 6144, 0, 0);
        add(0, 0,    1, 4096, 7168, 0, 1);
        add(0, 0,    1, 4096, 8192, 0, 1);
        // load with a simultaneous sample uses the old gain; then ramp to 4.0
        add(1, 16384, 1, 4096, 8192, 0, 0);
        for (int k = 0; k < 8; k++) add(0, 0, 1, 4096, 8192 + 1024 * k, 0, (k == 7));
        add(0, 0, 1, 32'sh4000_0000, exp_big_pos, exp_big_sat, 1);
        add(0, 0, 1, -32'sh4000_0000, exp_big_neg, exp_big_sat, 1);
        add(0, 0, 1, 4096, 16384, 0, 1);
        add(0, 0, 1, -100, -400,  0, 1);

        rst_n = 1'b0; in_valid = 1'b0; in_sample = '0; gain_load = 1'b0; target_gain = '0;
        tick();
        tick();
        check("reset_out_valid", longint'(out_valid), 0);
        check("reset_out_sample", longint'(out_sample), 0);
        check("reset_sat_flag", longint'(sat_flag), 0);
        check("reset_settled", longint'(gain_settled), 1);

        // unity gain, exact two-cycle latency
        rst_n = 1'b1;
        in_valid = 1'b1; in_sample = 1000;
        exp_out_q.push_back(1000); exp_sat_q.push_back(1'b0);
        tick();
        in_valid = 1'b0;
        check("lat_cycle1_valid", longint'(out_valid), 0);
        tick();
        check("lat_cycle2_valid", longint'(out_valid), 1);
        check("lat_cycle2_out", longint'(out_sample), 1000);
        check("lat_settled", longint'(gain_settled), 1);
        tick();
        check("lat_cycle3_valid", longint'(out_valid), 0);
        check("hold_out_sample", longint'(out_sample), 1000);

        for (int i = 0; i < vecs.size(); i++) begin
            gain_load   = vecs[i].ld;
            target_gain = vecs[i].tgt;
            in_valid    = vecs[i].iv;
            in_sample   = vecs[i].smp;
            if (vecs[i].iv) begin
                exp_out_q.push_back(vecs[i].exp_out);
                exp_sat_q.push_back(vecs[i].exp_sat);
            end
            tick();
            check($sformatf("settled_vec%0d", i), longint'(gain_settled), longint'(vecs[i].exp_settled));
        end
        gain_load = 1'b0; in_valid = 1'b0;
        tick(); tick(); tick();

        // reset with samples in flight mid-ramp
        gain_load = 1'b1; target_gain = 4096;
        tick();
        gain_load = 1'b0;
        check("f_ramping", longint'(gain_settled), 0);
        in_valid = 1'b1; in_sample = 4096;
        tick();
        rst_n = 1'b0; gain_load = 1'b1; target_gain = 0; in_sample = 2048;
        #1;
        check("f_settled_in_reset", longint'(gain_settled), 1);
        tick();
        check("f_out_valid", longint'(out_valid), 0);
        check("f_out_sample", longint'(out_sample), 0);
        check("f_sat_flag", longint'(sat_flag), 0);
        rst_n = 1'b1; gain_load = 1'b0; in_valid = 1'b0;
        for (int i = 0; i < 3; i++) begin
            tick();
            check("f_no_valid", longint'(out_valid), 0);
        end
        check("f_settled_after", longint'(gain_settled), 1);
        in_valid = 1'b1; in_sample = 4096;
        exp_out_q.push_back(4096); exp_sat_q.push_back(1'b0);
        tick();
        in_valid = 1'b0;
        tick();
        check("f_unity_out", longint'(out_sample), 4096);
        tick();
        check("pending_expectations", longint'(exp_out_q.size()), 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
